drop_sequencer: RTL and testbench

//  Sequential controller for the baggage-drop datapath. Accepts a start request, latches the sensor-derived

---
 rtl/drop_pkg.sv | 24 ++
 rtl/sqrt_iter.sv | 31 +++
 rtl/drop_sequencer.sv | 145 ++++++++++++++
 tb/tb_drop_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared types and widths for the baggage-drop sequencer: state encoding, display codes, root widths.
// Pure declarations, no logic and no timing.
package drop_pkg;

  localparam int HW   = 8;
  localparam int FRAC = 8;
  localparam int RW   = HW / 2 + FRAC;
  localparam int RADW = 2 * RW;
  localparam int TW   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SQRT   = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CODE_COLD = 2'd0,
    CODE_DROP = 2'd1,
    CODE_HOLD = 2'd2,
    CODE_IDLE = 2'd3
  } disp_e;

endpackage

// File: rtl/sqrt_iter.sv
// One restoring square-root step: shift two radicand bits into the remainder and try to set the next root bit.
// Purely combinational; no flow control.
module sqrt_iter #(
  parameter int RW = 12
) (
  input  logic [RW+1:0] rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [RW+1:0] rem_o,
  output logic [RW-1:0] root_o
);

  // Two spare bits hold the shifted remainder before the trial subtraction narrows it again.
  logic [RW+3:0] rem_sh;
  logic [RW+3:0] trial;
  logic [RW+3:0] diff;

  always_comb begin
    rem_sh = {rem_i, bits_i};
    trial  = {2'b00, root_i, 2'b01};
    diff   = rem_sh - trial;
    if (rem_sh >= trial) begin
      rem_o  = (RW+2)'(diff);
      root_o = {root_i[RW-2:0], 1'b1};
    end else begin
      rem_o  = (RW+2)'(rem_sh);
      root_o = {root_i[RW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/drop_sequencer.sv
// Drop controller: latches a request, runs a bit-serial 8.8 sqrt, registers fall time and drop decision.
// done pulses 13 edges after the accepting edge; start is ignored (not queued) while busy.
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int HW   = drop_pkg::HW,
  parameter int FRAC = drop_pkg::FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [HW-1:0] height,
  input  logic [15:0]   t_lim,
  input  logic          drop_en,
  output logic          busy,
  output logic          done,
  output logic [15:0]   t_act,
  output logic          drop_activated,
  output logic [1:0]    disp_code
);

  localparam int RWL  = HW / 2 + FRAC;
  localparam int RADL = 2 * RWL;
  localparam int CW   = $clog2(RWL);

  state_e            state_q, state_d;
  logic [RADL-1:0]   rad_q, rad_d;
  logic [RWL-1:0]    root_q, root_d;
  logic [RWL+1:0]    rem_q, rem_d;
  logic [CW-1:0]     iter_q, iter_d;
  logic [15:0]       tlim_q, tlim_d;
  logic              den_q, den_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       tact_q, tact_d;
  logic              dact_q, dact_d;
  disp_e             code_q, code_d;

  logic [RWL+1:0]    rem_nx;
  logic [RWL-1:0]    root_nx;
  logic [15:0]       t_calc;

  sqrt_iter #(.RW(RWL)) u_iter (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RADL-1 -: 2]),
    .rem_o  (rem_nx),
    .root_o (root_nx)
  );

  assign t_calc = 16'(root_q) >> 1;

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    iter_d  = iter_q;
    tlim_d  = tlim_q;
    den_d   = den_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tact_d  = tact_q;
    dact_d  = dact_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rad_d   = {height, {(2*FRAC){1'b0}}};
          root_d  = '0;
          rem_d   = '0;
          iter_d  = '0;
          tlim_d  = t_lim;
          den_d   = drop_en;
          busy_d  = 1'b1;
          state_d = S_SQRT;
        end
      end
      S_SQRT: begin
        // Radicand is consumed MSB pair first by shifting it out the top.
        rad_d  = rad_q << 2;
        root_d = root_nx;
        rem_d  = rem_nx;
        iter_d = iter_q + 1'b1;
        if (iter_q == CW'(RWL - 1)) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        tact_d = t_calc;
        if (t_calc <= tlim_q) begin
          dact_d = den_q;
          code_d = den_q ? CODE_DROP : CODE_HOLD;
        end else begin
          dact_d = 1'b0;
          code_d = CODE_COLD;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      iter_q  <= '0;
      tlim_q  <= '0;
      den_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tact_q  <= '0;
      dact_q  <= 1'b0;
      code_q  <= CODE_IDLE;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
      tlim_q  <= tlim_d;
      den_q   <= den_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tact_q  <= tact_d;
      dact_q  <= dact_d;
      code_q  <= code_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign t_act          = tact_q;
  assign drop_activated = dact_q;
  assign disp_code      = code_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Randomised scoreboard bench for drop_sequencer against a real-valued sqrt reference model.
module tb_drop_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  height;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        done;
  logic [15:0] t_act;
  logic        drop_activated;
  logic [1:0]  disp_code;

  drop_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .height         (height),
    .t_lim          (t_lim),
    .drop_en        (drop_en),
    .busy           (busy),
    .done           (done),
    .t_act          (t_act),
    .drop_activated (drop_activated),
    .disp_code      (disp_code)
  );

  typedef struct {
    int t;
    int dact;
    int code;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: floor(sqrt(h * 65536)) from real arithmetic, nudged to the exact integer floor.
  function automatic exp_t model(input int h, input int tl, input int den);
    exp_t e;
    longint v;
    longint r;
    v = longint'(h) * 65536;
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    e.t = int'(r / 2);
    if (e.t <= tl) begin
      e.dact = den;
      e.code = den ? 1 : 2;
    end else begin
      e.dact = 0;
      e.code = 0;
    end
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done high with no outstanding request at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("t_act", int'(t_act), e.t);
        chk("drop_activated", int'(drop_activated), e.dact);
        chk("disp_code", int'(disp_code), e.code);
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  // Drive a request at a negedge; returns at the following negedge with start low.
  task automatic issue(input int h, input int tl, input int den, input bit push);
    exp_t e;
    height  = 8'(h);
    t_lim   = 16'(tl);
    drop_en = den[0];
    start   = 1'b1;
    @(posedge clk);
    #1;
    e = model(h, tl, den);
    e.cyc = cyc + 13;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Waits at negedges for done; optionally scrambles inputs and pulses start meanwhile.
  task automatic wait_done(input bit mess);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (mess) begin
        start   = 1'($urandom);
        height  = 8'($urandom);
        t_lim   = 16'($urandom);
        drop_en = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    height  = '0;
    t_lim   = '0;
    drop_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_t_act", int'(t_act), 0);
    chk("rst_drop", int'(drop_activated), 0);
    chk("rst_code", int'(disp_code), 3);
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", int'(busy), 0);
    start = 1'b0;
    rst   = 1'b0;
    idle(2);

    issue(100, 16'h0600, 1, 1'b1);
    wait_done(1'b0);
    idle(2);

    issue(255, 16'h07FB, 1, 1'b1);
    wait_done(1'b0);
    idle(1);
    issue(255, 16'h07FA, 1, 1'b1);
    wait_done(1'b0);
    idle(1);
    issue(100, 16'hFFFF, 0, 1'b1);
    wait_done(1'b0);
    idle(1);
    issue(0, 0, 1, 1'b1);
    wait_done(1'b0);
    idle(1);

    issue(200, 16'h0700, 1, 1'b1);
    wait_done(1'b1);
    // Request during the done cycle is accepted on the next edge.
    issue(64, 16'h0400, 0, 1'b1);
    chk("done_fell", int'(done), 0);
    wait_done(1'b0);
    idle(3);

    issue(180, 16'h0800, 1, 1'b0);
    idle(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_t_act", int'(t_act), 0);
    chk("abort_drop", int'(drop_activated), 0);
    chk("abort_code", int'(disp_code), 3);
    idle(20);
    issue(150, 16'h0700, 1, 1'b1);
    wait_done(1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      int h;
      int tl;
      h  = int'($urandom_range(0, 255));
      tl = int'($urandom_range(0, 16'h0900));
      issue(h, tl, int'($urandom_range(0, 1)), 1'b1);
      wait_done(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(20);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
